// File: rtl/traffic_ctrl.sv
// rtl/traffic_ctrl.sv - two-road traffic light controller with pedestrian early cut and night flash
// Timing advances only on tick; lamps, walk lamps and remain are registered from the next-state values.
module traffic_ctrl #(
  parameter int TG   = 10,
  parameter int TY   = 5,
  parameter int TAR  = 2,
  parameter int TMIN = 4
) (
  input  logic       clk1,
  input  logic       clr,
  input  logic       tick,
  input  logic       ped_ns,
  input  logic       ped_ew,
  input  logic       night,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic [5:0] remain
);

  localparam logic [2:0] NS_G  = 3'd0;
  localparam logic [2:0] NS_Y  = 3'd1;
  localparam logic [2:0] AR1   = 3'd2;
  localparam logic [2:0] EW_G  = 3'd3;
  localparam logic [2:0] EW_Y  = 3'd4;
  localparam logic [2:0] AR2   = 3'd5;
  localparam logic [2:0] FLASH = 3'd6;

  localparam logic [5:0] D_G  = 6'(TG);
  localparam logic [5:0] D_Y  = 6'(TY);
  localparam logic [5:0] D_AR = 6'(TAR);
  // A green may be cut once remain has fallen to this value, i.e. on its TMIN-th tick.
  localparam logic [5:0] CUT  = 6'(TG - TMIN + 1);

  logic [2:0] state, state_n, succ;
  logic [5:0] remain_n;
  logic       blink, blink_n;
  logic       pns, pns_n;
  logic       pew, pew_n;
  logic       cut;

  function automatic logic [5:0] dur(input logic [2:0] s);
    case (s)
      NS_G, EW_G: dur = D_G;
      NS_Y, EW_Y: dur = D_Y;
      AR1, AR2:   dur = D_AR;
      default:    dur = 6'd0;
    endcase
  endfunction

  function automatic logic [2:0] ns_lamp(input logic [2:0] s, input logic b);
    case (s)
      NS_G:    ns_lamp = 3'b001;
      NS_Y:    ns_lamp = 3'b010;
      FLASH:   ns_lamp = {1'b0, b, 1'b0};
      default: ns_lamp = 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] ew_lamp(input logic [2:0] s, input logic b);
    case (s)
      EW_G:    ew_lamp = 3'b001;
      EW_Y:    ew_lamp = 3'b010;
      FLASH:   ew_lamp = {1'b0, b, 1'b0};
      default: ew_lamp = 3'b100;
    endcase
  endfunction

  always_comb begin
    cut = ((state == NS_G) && (pew || ped_ew) && (remain <= CUT)) ||
          ((state == EW_G) && (pns || ped_ns) && (remain <= CUT));
    case (state)
      NS_G:    succ = NS_Y;
      NS_Y:    succ = AR1;
      AR1:     succ = night ? FLASH : EW_G;
      EW_G:    succ = EW_Y;
      EW_Y:    succ = AR2;
      default: succ = night ? FLASH : NS_G;
    endcase
  end

  always_comb begin
    state_n  = state;
    remain_n = remain;
    blink_n  = blink;
    if (tick) begin
      case (state)
        FLASH: begin
          if (night) begin
            blink_n = ~blink;
          end else begin
            state_n  = AR2;
            remain_n = D_AR;
            blink_n  = 1'b0;
          end
        end
        3'd7: begin
          state_n  = AR2;
          remain_n = D_AR;
        end
        default: begin
          if ((remain == 6'd1) || cut) begin
            state_n  = succ;
            remain_n = dur(succ);
            blink_n  = (succ == FLASH);
          end else begin
            remain_n = remain - 6'd1;
          end
        end
      endcase
    end
    // Requests arriving while their green is entered or running are already served.
    pns_n = ((state == NS_G) || (state_n == NS_G)) ? 1'b0 : (pns | ped_ns);
    pew_n = ((state == EW_G) || (state_n == EW_G)) ? 1'b0 : (pew | ped_ew);
  end

  always_ff @(posedge clk1) begin
    if (clr) begin
      state    <= AR2;
      remain   <= D_AR;
      blink    <= 1'b0;
      pns      <= 1'b0;
      pew      <= 1'b0;
      ns_light <= 3'b100;
      ew_light <= 3'b100;
      walk_ns  <= 1'b0;
      walk_ew  <= 1'b0;
    end else begin
      state    <= state_n;
      remain   <= remain_n;
      blink    <= blink_n;
      pns      <= pns_n;
      pew      <= pew_n;
      ns_light <= ns_lamp(state_n, blink_n);
      ew_light <= ew_lamp(state_n, blink_n);
      walk_ns  <= (state_n == NS_G);
      walk_ew  <= (state_n == EW_G);
    end
  end

endmodule

// File: tb/tb_traffic_ctrl.sv
// tb/tb_traffic_ctrl.sv - randomized scoreboard bench for traffic_ctrl
// Phase model counts elapsed ticks per phase; expected outputs queue up per cycle for the monitor.
module tb_traffic_ctrl;

  localparam int TG   = 10;
  localparam int TY   = 5;
  localparam int TAR  = 2;
  localparam int TMIN = 4;

  logic       clk1 = 1'b0;
  logic       clr = 1'b1, tick = 1'b0, ped_ns = 1'b0, ped_ew = 1'b0, night = 1'b0;
  logic [2:0] ns_light, ew_light;
  logic       walk_ns, walk_ew;
  logic [5:0] remain;

  traffic_ctrl #(.TG(TG), .TY(TY), .TAR(TAR), .TMIN(TMIN)) dut (
    .clk1(clk1), .clr(clr), .tick(tick), .ped_ns(ped_ns), .ped_ew(ped_ew), .night(night),
    .ns_light(ns_light), .ew_light(ew_light), .walk_ns(walk_ns), .walk_ew(walk_ew), .remain(remain)
  );

  always #5 clk1 = ~clk1;

  int passed = 0;
  int total  = 0;
  logic [13:0] exp_q[$];

  // Phase index: 0 NS green, 1 NS yellow, 2 all-red 1, 3 EW green, 4 EW yellow, 5 all-red 2, 6 flash.
  int m_ph = 5, m_el = 0;
  bit m_pns = 0, m_pew = 0, m_blink = 0;

  function automatic int phase_len(input int p);
    if (p == 0 || p == 3) return TG;
    if (p == 1 || p == 4) return TY;
    if (p == 2 || p == 5) return TAR;
    return 0;
  endfunction

  function automatic logic [13:0] expect_word();
    logic [2:0] ns, ew;
    ns = 3'b100;
    ew = 3'b100;
    if (m_ph == 0) ns = 3'b001;
    if (m_ph == 1) ns = 3'b010;
    if (m_ph == 3) ew = 3'b001;
    if (m_ph == 4) ew = 3'b010;
    if (m_ph == 6) begin
      ns = m_blink ? 3'b010 : 3'b000;
      ew = ns;
    end
    return {ns, ew, (m_ph == 0), (m_ph == 3), 6'(phase_len(m_ph) - m_el)};
  endfunction

  task automatic m_step(input bit t, input bit pn, input bit pe, input bit ng, input bit c);
    int np, k;
    bit adv;
    if (c) begin
      m_ph = 5; m_el = 0; m_pns = 0; m_pew = 0; m_blink = 0;
      return;
    end
    np = m_ph;
    if (t) begin
      if (m_ph == 6) begin
        if (ng) m_blink = !m_blink;
        else begin np = 5; m_el = 0; m_blink = 0; end
      end else begin
        k = m_el + 1;
        adv = (k == phase_len(m_ph)) ||
              (m_ph == 0 && (m_pew || pe) && k >= TMIN) ||
              (m_ph == 3 && (m_pns || pn) && k >= TMIN);
        if (adv) begin
          m_el = 0;
          if ((m_ph == 2 || m_ph == 5) && ng) begin np = 6; m_blink = 1; end
          else np = (m_ph + 1) % 6;
        end else m_el = k;
      end
    end
    m_pns = (m_ph == 0 || np == 0) ? 0 : (m_pns | pn);
    m_pew = (m_ph == 3 || np == 3) ? 0 : (m_pew | pe);
    m_ph = np;
  endtask

  task automatic cyc(input bit t, input bit pn, input bit pe, input bit ng, input bit c);
    @(negedge clk1);
    tick = t; ped_ns = pn; ped_ew = pe; night = ng; clr = c;
    m_step(t, pn, pe, ng, c);
    exp_q.push_back(expect_word());
  endtask

  task automatic goto_ph(input int p, input bit ng);
    int n = 0;
    while (m_ph == p && n < 200) begin cyc(1, 0, 0, ng, 0); n++; end
    while (m_ph != p && n < 200) begin cyc(1, 0, 0, ng, 0); n++; end
    if (m_ph != p) begin
      total++;
      $display("FAIL goto_ph timeout: phase %0d, required %0d", m_ph, p);
    end
  endtask

  always @(posedge clk1) begin
    logic [13:0] e, got;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {ns_light, ew_light, walk_ns, walk_ew, remain};
      total++;
      if (got === e) passed++;
      else $display("FAIL outputs t=%0t: ns/ew/wns/wew/remain got %b %b %b %b %0d required %b %b %b %b %0d",
                    $time, got[13:11], got[10:8], got[7], got[6], got[5:0],
                    e[13:11], e[10:8], e[7], e[6], e[5:0]);
    end
  end

  initial begin
    bit ng;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    // Plain cycle with spaced ticks.
    for (int i = 0; i < 34; i++) begin
      cyc(1, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    end
    // ped_ns on EW green entry cuts it on its 4th tick.
    goto_ph(3, 0);
    cyc(0, 1, 0, 0, 0);
    goto_ph(4, 0);
    goto_ph(0, 0);
    // ped_ns on the 8th EW tick ends it immediately; ped_ns during NS green is discarded.
    goto_ph(3, 0);
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    goto_ph(0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    goto_ph(3, 0);
    goto_ph(4, 0);
    // Night flash, exit through AR2, ped_ew raised in flash cuts the next NS green.
    goto_ph(2, 0);
    goto_ph(6, 1);
    for (int i = 0; i < 5; i++) begin cyc(1, 0, 0, 1, 0); cyc(0, 0, 0, 1, 0); end
    cyc(0, 0, 1, 1, 0);
    goto_ph(5, 0);
    goto_ph(0, 0);
    goto_ph(1, 0);
    // Reset in NS yellow with remain 3 and a pending NS request.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    // Random ticks (including back-to-back), requests, night and rare resets.
    ng = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) ng = !ng;
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
          ng, ($urandom_range(0, 499) == 0));
    end
    cyc(0, 0, 0, 0, 0);
    @(negedge clk1);
    @(negedge clk1);
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl.md
TRAFFIC_CTRL -- requirements
Module: traffic_ctrl

Interface
REQ-001 Parameter TG, default 10: green phase length, in ticks.
REQ-002 Parameter TY, default 5: yellow phase length, in ticks.
REQ-003 Parameter TAR, default 2: all-red clearance length, in ticks.
REQ-004 Parameter TMIN, default 4: minimum green, in ticks, before a pedestrian request may cut a green short.
REQ-005 clk1  input  1  sole clock; all state changes on its rising edge.
REQ-006 clr  input  1  reset, synchronous and active-high.
REQ-007 tick  input  1  one-cycle pulse per second; clock enable for all phase timing.
REQ-008 ped_ns  input  1  pedestrian request to cross along NS (needs NS green); level or pulse.
REQ-009 ped_ew  input  1  pedestrian request to cross along EW (needs EW green).
REQ-010 night  input  1  night-mode request; both roads flash yellow.
REQ-011 ns_light  output  3  NS lamps {R,Y,G}, bit2=R, one-hot or 000.
REQ-012 ew_light  output  3  EW lamps {R,Y,G}, same encoding.
REQ-013 walk_ns  output  1  NS walk lamp.
REQ-014 walk_ew  output  1  EW walk lamp.
REQ-015 remain  output  6  ticks left in the current phase, for the countdown display.

Function
REQ-016 States SHALL be: NS_G, NS_Y, AR1, EW_G, EW_Y, AR2, FLASH. Outputs SHALL be registered and SHALL be a function of state only.
REQ-017 Lamps: NS_G = ns 001 / ew 100; NS_Y = 010 / 100; AR1 and AR2 = 100 / 100; EW_G = 100 / 001; EW_Y = 100 / 010; FLASH = both {0,blink,0}.
REQ-018 walk_ns SHALL be 1 only in NS_G, and walk_ew SHALL be 1 only in EW_G.
REQ-019 On entry to a state, remain SHALL load that state's duration: TG for greens, TY for yellows, TAR for all-reds, 0 for FLASH.
REQ-020 On a tick with remain>1, remain SHALL decrement by 1. On a tick with remain==1, the block SHALL advance to the next state and load that state's duration in the same cycle.
REQ-021 Without tick, state and remain SHALL hold. Each phase SHALL therefore last exactly its duration in ticks.
REQ-022 Normal sequence: NS_G->NS_Y->AR1->EW_G->EW_Y->AR2->NS_G.
REQ-023 A one-cycle assertion of ped_ns SHALL set pending flag pns; ped_ew SHALL set pew in the same way. Each flag SHALL hold until served.
REQ-024 pns SHALL clear in the cycle the block enters NS_G. ped_ns asserted in that entry cycle, or at any time while in NS_G, SHALL be discarded. pew behaves the same way with EW_G.
REQ-025 Early termination: in EW_G with pns=1, a tick with remain <= TG-TMIN+1 SHALL advance to EW_Y. NS_G with pew=1 behaves symmetrically.
REQ-026 With default parameters, early termination SHALL occur on the 4th tick of green at the earliest.
REQ-027 night SHALL be sampled only on the tick that ends AR1 or AR2. If night=1 on that tick, the next state SHALL be FLASH instead of a green.
REQ-028 In FLASH, internal bit blink SHALL toggle on every tick, starting at 1 on entry. remain SHALL be 0 and both walk lamps SHALL be 0.
REQ-029 FLASH exit: a tick with night=0 SHALL go to AR2 with remain=TAR, so the next green is NS_G.
REQ-030 Pending flags SHALL keep latching during FLASH and all-red states.
REQ-031 If the remain==1 advance and early termination both apply on the same tick, the block SHALL take a single advance to yellow.
REQ-032 tick asserted for consecutive cycles SHALL count as one tick per cycle; no edge detection is performed.

Reset
REQ-033 clr=1 at a clk1 edge SHALL force AR2, remain=TAR, ns_light=100, ew_light=100, walk_ns=walk_ew=0, pns=pew=0, blink=0. clr SHALL override tick, ped_ns, ped_ew and night.
REQ-034 clr asserted mid-phase, including FLASH, SHALL give the same result as REQ-033. The first tick after clr deasserts SHALL decrement remain to TAR-1.

Verification
REQ-035 Reset, then 34 ticks with no requests: AR2(2)->NS_G(10)->NS_Y(5)->AR1(2)->EW_G(10)->EW_Y(5)->AR2(2). remain counts down 10..1 in greens, and the light/walk pattern matches REQ-017 and REQ-018.
REQ-036 One-cycle ped_ns pulse on EW_G entry: EW_G ends on its 4th tick (remain 7->EW_Y, loads 5). Following NS_G shows walk_ns=1 and pns=0.
REQ-037 ped_ns pulse on the 8th tick of EW_G (remain 3): EW_G ends on that same tick. A ped_ns pulse during NS_G is discarded and the next EW_G runs the full 10 ticks.
REQ-038 night=1 held through AR1: FLASH is entered and both lamps alternate 010/000 each tick. Dropping night gives AR2 (2 ticks) then NS_G. A ped_ew raised in FLASH cuts the next NS_G at the 4th tick.
REQ-039 clr pulsed in NS_Y with remain=3 and pns=1: next cycle shows AR2, remain=2, lamps 100/100, pns=0. Random tick spacing including back-to-back ticks gives the same sequence as REQ-035.
